uart_tx_fifo: RTL and testbench

Byte buffer and launch sequencer sitting directly upstream of the UART transmitter. Accepts bytes from the CPU/bus side with a single-cycle write strobe, stores them in a power-of-two circular FIFO, and drains them one at a time into the transmitter via its `tx_start`/`tx_busy` handshake. This lets software queue up to `2**ADDR_W` bytes without polling the serial line.

---
 rtl/uart_tx_fifo.sv | 139 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO (depth 2**ADDR_W) feeding a UART transmitter through
// a tx_start/tx_busy handshake. Define UART_TX_FIFO_FLUSH_EN to add the
// synchronous flush_i port.
module uart_tx_fifo #(
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [7:0]        wr_data_i,
`ifdef UART_TX_FIFO_FLUSH_EN
    input  logic              flush_i,
`endif
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    output logic              tx_start_o,
    output logic [7:0]        tx_data_o,
    input  logic              tx_busy_i
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT
    } state_e;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    state_e            state_q, state_d;

    logic full_w, empty_w, flush_w, push_w, pop_w;

`ifdef UART_TX_FIFO_FLUSH_EN
    assign flush_w = flush_i;
`else
    assign flush_w = 1'b0;
`endif

    // Fullness is judged before any same-cycle pop, so a write into a full
    // FIFO is dropped even when a byte leaves on that edge.
    assign full_w  = (count_q == FULL_CNT);
    assign empty_w = (count_q == '0);
    assign push_w  = wr_en_i && !full_w && !flush_w;
    assign pop_w   = (state_q == S_IDLE) && !empty_w && !tx_busy_i && !flush_w;

    // Storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_w) mem_q[wr_ptr_q] <= wr_data_i;
    end

    // Pointer, occupancy and overflow next-state; flush wipes occupancy only.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = wr_en_i && full_w && !flush_w;
        if (flush_w) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_w) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (pop_w)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            case ({push_w, pop_w})
                2'b10:   count_d = count_q + (ADDR_W+1)'(1);
                2'b01:   count_d = count_q - (ADDR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Drain sequencer: launch one byte, hold until busy seen, wait for idle.
    always_comb begin
        state_d    = state_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        case (state_q)
            S_IDLE: begin
                if (pop_w) begin
                    tx_data_d  = mem_q[rd_ptr_q];
                    tx_start_d = 1'b1;
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (tx_busy_i) begin
                    tx_start_d = 1'b0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!tx_busy_i) state_d = S_IDLE;
            end
            default: begin
                tx_start_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            state_q    <= S_IDLE;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            state_q    <= state_d;
        end
    end

    assign full_o     = full_w;
    assign empty_o    = empty_w;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model plus launch scoreboard,
// a behavioural transmitter, directed scenarios and a random phase.
module tb_uart_tx_fifo;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [7:0]        wr_data = 8'h00;
    logic              tx_busy = 1'b0;
    logic              flush = 1'b0;
    logic              full, empty, overflow, tx_start;
    logic [ADDR_W:0]   count;
    logic [7:0]        tx_data;

    always #5 clk = ~clk;

    uart_tx_fifo #(.ADDR_W(ADDR_W)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
`ifdef UART_TX_FIFO_FLUSH_EN
        .flush_i    (flush),
`endif
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count),
        .overflow_o (overflow),
        .tx_start_o (tx_start),
        .tx_data_o  (tx_data),
        .tx_busy_i  (tx_busy)
    );

    int tests = 0;
    int fails = 0;
    logic [7:0] mq[$];     // bytes the model believes are stored, oldest first
    logic [7:0] sent[$];   // every byte launched by the DUT
    int launch_cnt = 0;

    // transmitter model state
    int busy_len = 3;
    bit force_busy = 1'b0;
    bit xbusy = 1'b0;
    bit pend = 1'b0;
    int bcnt = 0;

    // reference model state
    bit in_fl = 1'b0, seen_busy = 1'b0, exp_start = 1'b0, exp_ovf = 1'b0;
    int sz;
    bit prev_start = 1'b0;
    logic [7:0] last_data = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // Transmitter: accepts tx_start at an edge, raises busy on the next cycle.
    initial forever begin
        @(negedge clk);
        if (xbusy) begin
            if (bcnt == 0) xbusy = 1'b0;
            else bcnt--;
        end else if (pend) begin
            xbusy = 1'b1;
            bcnt  = busy_len;
            pend  = 1'b0;
        end else if (tx_start) begin
            pend = 1'b1;
        end
        tx_busy = xbusy | force_busy;
    end

    // Reference model: stores accepted writes, predicts tx_start and overflow.
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mq.delete();
            in_fl = 1'b0; seen_busy = 1'b0; exp_start = 1'b0; exp_ovf = 1'b0;
        end else begin
            sz = mq.size();
            if (!in_fl) begin
                if (sz > 0 && !tx_busy && !flush) begin
                    in_fl = 1'b1; seen_busy = 1'b0; exp_start = 1'b1;
                end
            end else if (!seen_busy) begin
                if (tx_busy) begin
                    seen_busy = 1'b1; exp_start = 1'b0;
                end
            end else if (!tx_busy) begin
                in_fl = 1'b0;
            end
            exp_ovf = 1'b0;
            if (flush) mq.delete();
            else if (wr_en) begin
                if (sz < DEPTH) mq.push_back(wr_data);
                else exp_ovf = 1'b1;
            end
            chk("tx_start", 32'(tx_start), 32'(exp_start));
            chk("overflow", 32'(overflow), 32'(exp_ovf));
        end
    end

    // Monitor: on each new launch pop the expected byte; check occupancy flags.
    initial forever begin
        @(posedge clk);
        #2;
        if (!rst_n) begin
            prev_start = 1'b0;
        end else begin
            if (tx_start && !prev_start) begin
                launch_cnt++;
                sent.push_back(tx_data);
                if (mq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL launch_from_empty: got data 0x%0h, expected no launch at %0t", tx_data, $time);
                end else begin
                    chk("tx_data_order", 32'(tx_data), 32'(mq.pop_front()));
                end
            end else if (tx_start) begin
                chk("tx_data_stable", 32'(tx_data), 32'(last_data));
            end
            last_data  = tx_data;
            prev_start = tx_start;
            chk("count", 32'(count), 32'(mq.size()));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("full",  32'(full),  32'(mq.size() == DEPTH));
        end
    end

    task automatic wait_idle(input int lim);
        int stable = 0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (empty && !tx_start && !tx_busy && !pend) stable++;
            else stable = 0;
            if (stable >= 3) return;
        end
        timeout("wait_idle");
    endtask

    initial begin
        int base;
        bit done;
        #400000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        int base;
        bit done;

        // reset held with a write strobe active
        wr_en = 1'b1; wr_data = 8'h3C;
        repeat (3) @(negedge clk);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_overflow", 32'(overflow), 0);
        wr_en = 1'b0; rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_no_launch", launch_cnt, 0);

        // single byte, launch latency and tx_start width
        busy_len = 3;
        @(negedge clk); wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clk); wr_en = 1'b0;
        chk("single_not_yet", 32'(tx_start), 0);
        @(negedge clk);
        chk("single_start", 32'(tx_start), 1);
        chk("single_data", 32'(tx_data), 'hA5);
        @(negedge clk);
        chk("single_start_held", 32'(tx_start), 1);
        @(negedge clk);
        chk("single_start_drop", 32'(tx_start), 0);
        chk("single_empty", 32'(empty), 1);
        wait_idle(100);

        // ordering with a slow transmitter
        busy_len = 20;
        base = sent.size();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk); wr_en = 1'b1; wr_data = 8'(i);
        end
        @(negedge clk); wr_en = 1'b0;
        wait_idle(400);
        chk("order_count", sent.size() - base, 5);
        for (int i = 0; i < 5 && base + i < sent.size(); i++)
            chk("order_byte", 32'(sent[base+i]), i + 1);

        // fill to full, overflow pulse, then drain
        force_busy = 1'b1;
        repeat (3) @(negedge clk);
        busy_len = 1;
        base = launch_cnt;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i == 15) chk("full_at_15", 32'(full), 0);
            if (i == 16) begin
                chk("full_at_16", 32'(full), 1);
                chk("count_at_16", 32'(count), 16);
            end
            wr_en = 1'b1; wr_data = 8'($urandom);
        end
        @(negedge clk); wr_en = 1'b0;
        chk("ovf_pulse", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 16);
        @(negedge clk);
        chk("ovf_cleared", 32'(overflow), 0);
        force_busy = 1'b0;
        wait_idle(600);
        chk("drain_count", launch_cnt - base, 16);

        // wrap: fill 10, drain 8, then 12 writes overlapping pops
        force_busy = 1'b1;
        repeat (3) @(negedge clk);
        base = launch_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); wr_en = 1'b1; wr_data = 8'($urandom);
        end
        @(negedge clk); wr_en = 1'b0;
        busy_len = 0; force_busy = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (launch_cnt - base >= 8) done = 1'b1;
        end
        if (!done) timeout("wrap_drain8");
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); wr_en = 1'b1; wr_data = 8'($urandom);
        end
        @(negedge clk); wr_en = 1'b0;
        wait_idle(600);
        chk("wrap_total", launch_cnt - base, 22);

        // random traffic with varying transmitter busy time
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            busy_len = $urandom_range(0, 4);
            wr_en    = ($urandom_range(0, 99) < 60);
            wr_data  = 8'($urandom);
        end
        @(negedge clk); wr_en = 1'b0;
        wait_idle(1500);

        // reset while in WAIT with 6 bytes queued
        busy_len = 20;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); wr_en = 1'b1; wr_data = 8'(8'h70 + i);
        end
        @(negedge clk); wr_en = 1'b0;
        chk("midrst_waiting", 32'(tx_start), 0);
        chk("midrst_queued", 32'(count), 6);
        rst_n = 1'b0;
        #1;
        chk("midrst_count", 32'(count), 0);
        chk("midrst_empty", 32'(empty), 1);
        chk("midrst_full", 32'(full), 0);
        chk("midrst_tx_start", 32'(tx_start), 0);
        chk("midrst_tx_data", 32'(tx_data), 0);
        chk("midrst_overflow", 32'(overflow), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = launch_cnt;
        repeat (60) @(negedge clk);
        chk("midrst_no_launch", launch_cnt - base, 0);
        wait_idle(200);

`ifdef UART_TX_FIFO_FLUSH_EN
        // flush during LAUNCH: in-flight byte completes, rest discarded
        busy_len = 10;
        base = launch_cnt;
        @(negedge clk); wr_en = 1'b1; wr_data = 8'hC1;
        @(negedge clk); wr_data = 8'hC2;
        @(negedge clk); wr_data = 8'hC3;
        @(negedge clk); wr_data = 8'hC4; flush = 1'b1;
        chk("flush_in_launch", 32'(tx_start), 1);
        @(negedge clk); wr_en = 1'b0; flush = 1'b0;
        chk("flush_count", 32'(count), 0);
        chk("flush_empty", 32'(empty), 1);
        wait_idle(200);
        chk("flush_launches", launch_cnt - base, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
